mean3_feeder: RTL

MEAN3_FEEDER -- requirements
Module: mean3_feeder

---
 rtl/mean3_feeder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mean3_feeder.sv
// Collects three sample bytes, launches them into a downstream mean unit
// and captures its result; a missing busy response raises a sticky error.
module mean3_feeder #(
  parameter int C_DELAY      = 2,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       start,
  output logic [7:0] InA,
  output logic [7:0] InB,
  input  logic       busy,
  input  logic [7:0] mean_in,
  output logic [7:0] res_data,
  output logic       res_valid,
  output logic       err
);

  localparam int CMAXI =
    (C_DELAY > BUSY_TIMEOUT) ? C_DELAY : BUSY_TIMEOUT;
  localparam int CW = (CMAXI < 1) ? 1 : $clog2(CMAXI + 1);
  localparam logic [CW-1:0] CMAX = CW'(CMAXI);
  localparam logic [CW-1:0] CDLY = CW'(C_DELAY);
  localparam logic [CW-1:0] TMO  = CW'(BUSY_TIMEOUT);

  typedef enum logic [2:0] {
    FILL, LAUNCH, WAIT_C, WAIT_BUSY, CAPTURE
  } state_t;

  state_t        state_q;
  logic [1:0]    count_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [7:0]    rega_q, regb_q, regc_q;
  logic [7:0]    ina_q, inb_q, ina_d;
  logic [7:0]    res_q;
  logic          start_q, rv_q, err_q, seen_q;

  // Counter saturates, so it never wraps back under the thresholds.
  assign cnt_d = (cnt_q >= CMAX) ? cnt_q : cnt_q + 1'b1;
  assign ina_d = (cnt_d >= CDLY) ? regc_q : rega_q;

  assign in_ready  = (state_q == FILL);
  assign start     = start_q;
  assign InA       = ina_q;
  assign InB       = inb_q;
  assign res_data  = res_q;
  assign res_valid = rv_q;
  assign err       = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      count_q <= '0;
      cnt_q   <= '0;
      rega_q  <= '0;
      regb_q  <= '0;
      regc_q  <= '0;
      ina_q   <= '0;
      inb_q   <= '0;
      res_q   <= '0;
      start_q <= 1'b0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      rv_q    <= 1'b0;
      unique case (state_q)
        FILL: begin
          if (in_valid) begin
            if (count_q == 2'd0) rega_q <= in_data;
            if (count_q == 2'd1) regb_q <= in_data;
            if (count_q == 2'd2) begin
              regc_q  <= in_data;
              count_q <= '0;
              cnt_q   <= '0;
              state_q <= LAUNCH;
              start_q <= 1'b1;
              ina_q   <= (C_DELAY == 0) ? in_data : rega_q;
              inb_q   <= regb_q;
            end else begin
              count_q <= count_q + 2'd1;
            end
          end
        end
        LAUNCH: begin
          cnt_q   <= cnt_d;
          ina_q   <= ina_d;
          state_q <= WAIT_C;
        end
        WAIT_C: begin
          cnt_q  <= cnt_d;
          ina_q  <= ina_d;
          seen_q <= seen_q | busy;
          if (cnt_d >= CDLY) state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          cnt_q  <= cnt_d;
          ina_q  <= ina_d;
          seen_q <= seen_q | busy;
          if (seen_q && !busy) begin
            state_q <= CAPTURE;
            res_q   <= mean_in;
            rv_q    <= 1'b1;
          end else if (!seen_q && !busy && cnt_d >= TMO) begin
            err_q   <= 1'b1;
            state_q <= FILL;
            ina_q   <= '0;
            inb_q   <= '0;
            seen_q  <= 1'b0;
          end
        end
        CAPTURE: begin
          state_q <= FILL;
          ina_q   <= '0;
          inb_q   <= '0;
          seen_q  <= 1'b0;
        end
        default: state_q <= FILL;
      endcase
    end
  end

endmodule
